mv_cmd_seq: RTL

- Sequences the PID steering datapath for one move command: heading change, then forward travel of N squares.
- Generates the PID's `moving`, `err_vld`, `error` and `frwrd` inputs from the gyro heading and the centre-line IR sensor.
- Sits between the command processor (upstream) and PID (downstream); the PID's integrator is cleared whenever `moving` drops.

---
 rtl/mv_seq_pkg.sv | 28 ++
 rtl/mv_cmd_seq_ir_edge_cnt.sv | 36 +++
 rtl/mv_cmd_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mv_seq_pkg.sv
// ---------------------------------------------------------------------------
// mv_seq_pkg: shared state encoding, ramp steps and defaults for mv_cmd_seq.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mv_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_TURN   = 3'd1;
  localparam logic [2:0] ST_ACCEL  = 3'd2;
  localparam logic [2:0] ST_CRUISE = 3'd3;
  localparam logic [2:0] ST_DECEL  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [9:0]  INC_NORM    = 10'h003;
  localparam logic [9:0]  INC_FAST    = 10'h020;
  localparam logic [9:0]  DEF_MAX_SPD = 10'h2A0;
  localparam logic [11:0] DEF_HDG_TOL = 12'h02C;

  // Two's-complement magnitude; 12'h800 maps to itself and so always exceeds any tolerance.
  function automatic logic [11:0] mag12(input logic [11:0] v);
    return v[11] ? (~v + 12'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mv_cmd_seq_ir_edge_cnt.sv
// ---------------------------------------------------------------------------
// ir_edge_cnt: synchronises the centre-line IR sensor and counts rising edges.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ir_edge_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_async,
  input  logic       clr,
  output logic [4:0] xing
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised value.
  logic [2:0] sync;
  logic       rise;

  assign rise = sync[1] & ~sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b000;
      xing <= 5'd0;
    end else begin
      sync <= {sync[1:0], ir_async};
      if (clr)
        xing <= 5'd0;
      else if (rise)
        xing <= xing + 5'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mv_cmd_seq.sv
// ---------------------------------------------------------------------------
// mv_cmd_seq: sequences one move (turn to heading, then travel N squares) for the PID.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mv_cmd_seq
  import mv_seq_pkg::*;
#(
  parameter bit          FAST_SIM   = 1'b0,
  parameter logic [9:0]  MAX_SPD    = DEF_MAX_SPD,
  parameter logic [11:0] HDG_TOL    = DEF_HDG_TOL,
  parameter logic [2:0]  SETTLE_CNT = 3'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_go,
  input  logic [11:0] cmd_hdg,
  input  logic [3:0]  cmd_sqrs,
  output logic        cmd_rdy,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  output logic        moving,
  output logic        err_vld,
  output logic [11:0] error,
  output logic [9:0]  frwrd,
  output logic        mv_done
);

  localparam logic [9:0] INC = FAST_SIM ? INC_FAST : INC_NORM;
  localparam logic [9:0] DEC = {INC[8:0], 1'b0};

  logic [2:0]  state;
  logic [11:0] des_hdg;
  logic [3:0]  sqrs;
  logic [2:0]  settle;
  logic [4:0]  xing;
  logic        go_ok;
  logic        at_target;
  logic        in_tol;
  logic [10:0] up_sum;
  logic        up_sat;

  assign go_ok     = cmd_go && (state == ST_IDLE);
  assign at_target = (xing == {sqrs, 1'b0});
  assign in_tol    = (mag12(error) <= HDG_TOL);
  assign up_sum    = {1'b0, frwrd} + {1'b0, INC};
  assign up_sat    = (up_sum >= {1'b0, MAX_SPD});

  assign cmd_rdy = (state == ST_IDLE);
  assign mv_done = (state == ST_DONE);
  assign moving  = (state == ST_TURN) || (state == ST_ACCEL) ||
                   (state == ST_CRUISE) || (state == ST_DECEL);

  ir_edge_cnt u_ir_edge_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir_async (cntrIR),
    .clr      (go_ok),
    .xing     (xing)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error   <= 12'd0;
      err_vld <= 1'b0;
    end else begin
      err_vld <= heading_rdy & moving;
      if (heading_rdy)
        error <= heading - des_hdg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      des_hdg <= 12'd0;
      sqrs    <= 4'd0;
      settle  <= 3'd0;
      frwrd   <= 10'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          frwrd  <= 10'd0;
          settle <= 3'd0;
          if (cmd_go) begin
            des_hdg <= cmd_hdg;
            sqrs    <= cmd_sqrs;
            state   <= ST_TURN;
          end
        end
        ST_TURN: begin
          if (err_vld) begin
            if (!in_tol)
              settle <= 3'd0;
            else if (settle == SETTLE_CNT - 3'd1) begin
              settle <= 3'd0;
              state  <= (sqrs == 4'd0) ? ST_DONE : ST_ACCEL;
            end else
              settle <= settle + 3'd1;
          end
        end
        ST_ACCEL: begin
          if (heading_rdy)
            frwrd <= up_sat ? MAX_SPD : up_sum[9:0];
          // Reaching the square count wins over reaching cruise speed.
          if (at_target)
            state <= ST_DECEL;
          else if (heading_rdy && up_sat)
            state <= ST_CRUISE;
        end
        ST_CRUISE: begin
          if (at_target)
            state <= ST_DECEL;
        end
        ST_DECEL: begin
          // Leave in the same cycle frwrd lands on 0 so moving drops with it.
          if (frwrd == 10'd0)
            state <= ST_DONE;
          else if (heading_rdy) begin
            if (frwrd <= DEC) begin
              frwrd <= 10'd0;
              state <= ST_DONE;
            end else
              frwrd <= frwrd - DEC;
          end
        end
        ST_DONE: begin
          frwrd <= 10'd0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
